// File: rtl/yolo_accel_core.sv
// yolo_accel_core: int8 lane stream post-processor (bypass/ReLU/scale/leaky); define YOLO_ACCEL_TLAST_CHECK_EN to end a task early on input tlast.
module yolo_accel_core #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                  sclk,
    input  logic                  s_rst_n,
    input  logic [31:0]           slave_lite_reg0,
    input  logic [31:0]           slave_lite_reg1,
    input  logic [31:0]           slave_lite_reg2,
    input  logic [31:0]           slave_lite_reg3,
    input  logic [DATA_W-1:0]     s_axis_mm2s_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_mm2s_tkeep,
    input  logic                  s_axis_mm2s_tvalid,
    output logic                  s_axis_mm2s_tready,
    input  logic                  s_axis_mm2s_tlast,
    output logic [DATA_W-1:0]     s_axis_s2mm_tdata,
    output logic [DATA_W/8-1:0]   s_axis_s2mm_tkeep,
    output logic                  s_axis_s2mm_tvalid,
    input  logic                  s_axis_s2mm_tready,
    output logic                  s_axis_s2mm_tlast,
    output logic                  task_finish
);
    localparam int LANES = DATA_W / 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic start_q, start, in_fire, out_fire, last_in, unused_ok;
    logic [1:0] mode_q;
    logic [3:0] shift_q;
    logic [CNT_W-1:0] cnt_q, in_cnt;
    logic signed [7:0] scale_q, bias_q;
    logic [DATA_W-1:0] res;

    function automatic logic [7:0] lane_op(input logic [1:0] m, input logic signed [7:0] x, sc, bi,
                                           input logic [3:0] sh);
        logic signed [15:0] p;
        logic signed [16:0] s;
        p = (x * sc) >>> sh;
        s = $signed({p[15], p}) + $signed({{9{bi[7]}}, bi});
        return (m == 2'd0) ? x :
               (m == 2'd1) ? (x[7] ? 8'h00 : x) :
               (m == 2'd2) ? ((s > 17'sd127) ? 8'h7f : (s < -17'sd128) ? 8'h80 : s[7:0]) :
               (x[7] ? 8'(x >>> 3) : x);
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign res[8*i +: 8] = s_axis_mm2s_tkeep[i]
            ? lane_op(mode_q, $signed(s_axis_mm2s_tdata[8*i +: 8]), scale_q, bias_q, shift_q) : 8'h00;
    end

    assign start              = slave_lite_reg0[2] & ~start_q;
    assign s_axis_mm2s_tready = (state == RUN) && (in_cnt < cnt_q) && (!s_axis_s2mm_tvalid || s_axis_s2mm_tready);
    assign in_fire            = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
    assign out_fire           = s_axis_s2mm_tvalid & s_axis_s2mm_tready;
    assign task_finish        = state == DONE;
`ifdef YOLO_ACCEL_TLAST_CHECK_EN
    assign last_in   = (in_cnt == cnt_q - CNT_W'(1)) || s_axis_mm2s_tlast;
    assign unused_ok = ^{slave_lite_reg2, slave_lite_reg3, slave_lite_reg0[31:24], slave_lite_reg0[3],
                         slave_lite_reg1[31:16]};
`else
    assign last_in   = in_cnt == cnt_q - CNT_W'(1);
    assign unused_ok = ^{slave_lite_reg2, slave_lite_reg3, slave_lite_reg0[31:24], slave_lite_reg0[3],
                         slave_lite_reg1[31:16], s_axis_mm2s_tlast};
`endif

    always_ff @(posedge sclk or negedge s_rst_n)
        if (!s_rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        if (state == IDLE && start) nxt = (slave_lite_reg0[8 +: CNT_W] == '0) ? DONE : RUN;
        else if (state == RUN && out_fire && s_axis_s2mm_tlast) nxt = DONE;
        else if (state == DONE) nxt = IDLE;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            start_q            <= 1'b0;
            mode_q             <= '0;
            shift_q            <= '0;
            cnt_q              <= '0;
            scale_q            <= '0;
            bias_q             <= '0;
            in_cnt             <= '0;
            s_axis_s2mm_tdata  <= '0;
            s_axis_s2mm_tkeep  <= '0;
            s_axis_s2mm_tvalid <= 1'b0;
            s_axis_s2mm_tlast  <= 1'b0;
        end else begin
            start_q <= slave_lite_reg0[2];
            if (state == IDLE && start) begin
                mode_q  <= slave_lite_reg0[1:0];
                shift_q <= slave_lite_reg0[7:4];
                cnt_q   <= slave_lite_reg0[8 +: CNT_W];
                scale_q <= slave_lite_reg1[7:0];
                bias_q  <= slave_lite_reg1[15:8];
                in_cnt  <= '0;
            end else if (in_fire) begin
                in_cnt <= last_in ? cnt_q : in_cnt + CNT_W'(1);
            end
            if (in_fire) begin
                s_axis_s2mm_tdata  <= res;
                s_axis_s2mm_tkeep  <= s_axis_mm2s_tkeep;
                s_axis_s2mm_tvalid <= 1'b1;
                s_axis_s2mm_tlast  <= last_in;
            end else if (s_axis_s2mm_tready) begin
                s_axis_s2mm_tvalid <= 1'b0;
                s_axis_s2mm_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_yolo_accel_core.sv
// tb_yolo_accel_core: directed checks of yolo_accel_core modes, backpressure, busy start, reset.
module tb_yolo_accel_core;
    logic        sclk, s_rst_n;
    logic [31:0] slave_lite_reg0, slave_lite_reg1, slave_lite_reg2, slave_lite_reg3;
    logic [63:0] s_axis_mm2s_tdata, s_axis_s2mm_tdata;
    logic [7:0]  s_axis_mm2s_tkeep, s_axis_s2mm_tkeep;
    logic        s_axis_mm2s_tvalid, s_axis_mm2s_tready, s_axis_mm2s_tlast;
    logic        s_axis_s2mm_tvalid, s_axis_s2mm_tready, s_axis_s2mm_tlast, task_finish;
    int total = 0, bad = 0;

    yolo_accel_core dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .slave_lite_reg0(slave_lite_reg0), .slave_lite_reg1(slave_lite_reg1),
        .slave_lite_reg2(slave_lite_reg2), .slave_lite_reg3(slave_lite_reg3),
        .s_axis_mm2s_tdata(s_axis_mm2s_tdata), .s_axis_mm2s_tkeep(s_axis_mm2s_tkeep),
        .s_axis_mm2s_tvalid(s_axis_mm2s_tvalid), .s_axis_mm2s_tready(s_axis_mm2s_tready),
        .s_axis_mm2s_tlast(s_axis_mm2s_tlast),
        .s_axis_s2mm_tdata(s_axis_s2mm_tdata), .s_axis_s2mm_tkeep(s_axis_s2mm_tkeep),
        .s_axis_s2mm_tvalid(s_axis_s2mm_tvalid), .s_axis_s2mm_tready(s_axis_s2mm_tready),
        .s_axis_s2mm_tlast(s_axis_s2mm_tlast), .task_finish(task_finish)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ":tvalid"}, 64'(s_axis_s2mm_tvalid), 64'd0);
        chk({tag, ":tdata"}, s_axis_s2mm_tdata, 64'd0);
        chk({tag, ":tkeep"}, 64'(s_axis_s2mm_tkeep), 64'd0);
        chk({tag, ":tlast"}, 64'(s_axis_s2mm_tlast), 64'd0);
        chk({tag, ":mm2s_tready"}, 64'(s_axis_mm2s_tready), 64'd0);
        chk({tag, ":finish"}, 64'(task_finish), 64'd0);
    endtask

    task automatic stream(input string tag, input logic [31:0] r0, input int n, input logic [63:0] base,
                          input logic [63:0] xexp, input logic [7:0] keep, input bit inc,
                          input bit toggle, input bit kick);
        int sent, got, fins, cyc;
        bit running, m_valid, m_last, m_fin, ended, kicked, fi, fo, exp_rdy;
        logic [63:0] m_data;
        sent = 0; got = 0; fins = 0; cyc = 0;
        running = n != 0; m_valid = 0; m_last = 0; m_fin = n == 0; ended = 0; kicked = 0;
        m_data = '0;
        @(negedge sclk);
        slave_lite_reg0 = r0 | 32'd4;
        @(negedge sclk);
        slave_lite_reg0 = r0;
        while (1) begin
            chk({tag, ":tvalid"}, 64'(s_axis_s2mm_tvalid), 64'(m_valid));
            chk({tag, ":finish"}, 64'(task_finish), 64'(m_fin));
            if (m_valid) begin
                chk({tag, ":tdata"}, s_axis_s2mm_tdata, m_data);
                chk({tag, ":tkeep"}, 64'(s_axis_s2mm_tkeep), 64'(keep));
                chk({tag, ":tlast"}, 64'(s_axis_s2mm_tlast), 64'(m_last));
            end
            fins += int'(task_finish);
            if (ended) break;
            ended = m_fin;
            s_axis_mm2s_tvalid = sent < n;
            s_axis_mm2s_tdata  = inc ? base + 64'(sent) : base;
            s_axis_mm2s_tkeep  = keep;
            s_axis_s2mm_tready = toggle ? cyc[0] : 1'b1;
            if (kick && !kicked && sent == 10) begin
                slave_lite_reg0 = r0 | 32'd4;
                kicked = 1;
            end else begin
                slave_lite_reg0 = r0;
            end
            #1;
            exp_rdy = running && sent < n && (!m_valid || s_axis_s2mm_tready);
            chk({tag, ":mm2s_tready"}, 64'(s_axis_mm2s_tready), 64'(exp_rdy));
            fi = exp_rdy;
            fo = m_valid && s_axis_s2mm_tready;
            m_fin = fo && m_last;
            if (fo) begin
                got++;
                if (m_last) running = 0;
            end
            if (fi) begin
                m_valid = 1;
                m_data  = inc ? base + 64'(sent) : xexp;
                m_last  = sent == n - 1;
                sent++;
            end else if (fo) begin
                m_valid = 0;
            end
            cyc++;
            if (cyc > 3 * n + 20) begin
                chk({tag, ":timeout_cycles"}, 64'(cyc), 64'(3 * n + 20));
                break;
            end
            @(negedge sclk);
        end
        s_axis_mm2s_tvalid = 0;
        s_axis_s2mm_tready = 1;
        slave_lite_reg0    = r0;
        chk({tag, ":beats"}, 64'(got), 64'(n));
        chk({tag, ":finish_pulses"}, 64'(fins), 64'd1);
    endtask

    initial begin
        s_rst_n = 0;
        slave_lite_reg0 = '0; slave_lite_reg1 = '0; slave_lite_reg2 = '0; slave_lite_reg3 = '0;
        s_axis_mm2s_tdata = '0; s_axis_mm2s_tkeep = '0; s_axis_mm2s_tvalid = 0; s_axis_mm2s_tlast = 0;
        s_axis_s2mm_tready = 1;
        repeat (2) @(negedge sclk);
        chk_idle_outputs("reset");
        s_rst_n = 1;

        stream("bypass", 32'h000400, 4, 64'h0102030405060708, 64'h0102030405060708, 8'hFF, 0, 0, 0);
        stream("relu", 32'h000101, 1, 64'h80FF017F00FE0203, 64'h0000017F00000203, 8'hFF, 0, 0, 0);
        slave_lite_reg1 = 32'h0000_0510;
        stream("scale", 32'h000122, 1, 64'h00000000FD02807F, 64'h05050505F90D807F, 8'hFF, 0, 0, 0);
        stream("leaky", 32'h000103, 1, 64'hF8807F0100FFC010, 64'hFFF07F0100FFF810, 8'hFF, 0, 0, 0);
        stream("keep", 32'h000100, 1, 64'h1122334455667788, 64'h0022004455007700, 8'h5A, 0, 0, 0);
        stream("count0", 32'h000000, 0, 64'h0, 64'h0, 8'hFF, 0, 0, 0);
        stream("backpressure", 32'h000800, 8, 64'h00000000000000A0, 64'h0, 8'hFF, 1, 1, 0);
        stream("busy", 32'h66D780, 32'h66D7, 64'h0, 64'h0, 8'hFF, 1, 0, 1);

        @(negedge sclk);
        slave_lite_reg0 = 32'h000404;
        @(negedge sclk);
        slave_lite_reg0 = 32'h000400;
        s_axis_mm2s_tvalid = 1;
        s_axis_mm2s_tdata  = 64'h0102030405060708;
        s_axis_mm2s_tkeep  = 8'hFF;
        s_axis_s2mm_tready = 1;
        repeat (3) @(negedge sclk);
        chk("pre_reset:tvalid", 64'(s_axis_s2mm_tvalid), 64'd1);
        #2 s_rst_n = 0;
        #1 chk_idle_outputs("mid_reset");
        @(negedge sclk);
        s_rst_n = 1;
        s_axis_mm2s_tvalid = 0;
        stream("after_reset", 32'h000400, 4, 64'h0000000000000010, 64'h0, 8'hFF, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/yolo_accel_core.md
Name: yolo_accel_core

Overview:
Streaming post-processing engine of the YOLO accelerator, sitting between the AXI DMA MM2S stream and the S2MM stream. Software writes a task descriptor into AXI4-Lite register 0 and pulses its start bit. The block then consumes a programmed number of 64-bit beats (8 signed int8 lanes) and applies a per-lane activation/quantisation. It emits the results on the S2MM stream and pulses task_finish as the interrupt source.

Parameters:
DATA_W, 64, stream data width (8 int8 lanes)
CNT_W, 16, width of the beat counter

Ports:
sclk  in  1  system clock
s_rst_n  in  1  reset; one clock; asynchronous, active-low
slave_lite_reg0  in  32  control: [1:0] mode, [2] start, [3] reserved, [7:4] shift, [23:8] beat count, [31:24] reserved
slave_lite_reg1  in  32  [7:0] signed scale, [15:8] signed bias, rest reserved
slave_lite_reg2  in  32  reserved, ignored
slave_lite_reg3  in  32  reserved, ignored
s_axis_mm2s_tdata  in  64  input lanes, lane i = bits [8i+7:8i]
s_axis_mm2s_tkeep  in  8  input byte enables
s_axis_mm2s_tvalid  in  1  input valid
s_axis_mm2s_tready  out  1  input ready
s_axis_mm2s_tlast  in  1  input last (ignored unless option enabled)
s_axis_s2mm_tdata  out  64  result lanes
s_axis_s2mm_tkeep  out  8  result byte enables
s_axis_s2mm_tvalid  out  1  result valid
s_axis_s2mm_tready  in  1  downstream ready
s_axis_s2mm_tlast  out  1  last beat of task
task_finish  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; start edge register 0.
- Start detection: register reg0[2] each cycle. Start = current 1 and previous 0. In IDLE, latch mode, shift, count, scale and bias, then go to RUN. A start while in RUN is ignored.
- Count 0: RUN is skipped. task_finish pulses the cycle after start; no transfers occur.
- States: IDLE -> RUN on start. RUN -> DONE when the output beat numbered count-1 is accepted (tvalid & tready). DONE -> IDLE after one cycle, during which task_finish = 1.
- Pipeline: one output register stage.
  - s_axis_mm2s_tready = RUN & (beats taken < count) & (!s2mm_tvalid | s2mm_tready).
  - The result of an input handshake appears on the S2MM outputs the next cycle.
  - The output holds stable while tvalid=1 and tready=0.
  - With tready held at 1, throughput is 1 beat/clock.
- Lane arithmetic, x is a signed 8-bit lane:
  - mode 0 bypass: y = x.
  - mode 1 ReLU: y = x<0 ? 0 : x.
  - mode 2 scale: y = sat8(((x*scale) >>> shift) + bias). The product is 16-bit signed, the shift is arithmetic, the sum is 17-bit, and sat8 clamps to [-128,127].
  - mode 3 leaky: y = x<0 ? (x >>> 3) : x.
- tkeep: output tkeep = input tkeep. Lanes with keep=0 output 0x00.
- tlast: s2mm_tlast = 1 only on beat count-1.
- Counters wrap to 0 at each new start.
- Register 0 fields are sampled only at start; later writes do not affect a running task.

Optional Feature:
Macro YOLO_ACCEL_TLAST_CHECK_EN.
- Defined: an input beat with s_axis_mm2s_tlast=1 before beat count-1 ends the task early.
  - That beat is output with s2mm_tlast=1.
  - On its acceptance the block goes to DONE and pulses task_finish.
  - tlast on the final programmed beat is normal.
- Not defined: s_axis_mm2s_tlast is ignored; task length is set by count only.

Test Plan:
- Bypass: reg0 0x000404 then 0x000400; 4 beats 0x0102030405060708 with tkeep 0xFF; s2mm tready=1 -> same 4 beats one cycle after each input; tlast on beat 4; task_finish one cycle after beat 4 is accepted.
- ReLU: mode 1, count 1, input 0x80FF017F00FE0203 -> output 0x0000017F00000203.
- Scale saturation: mode 2, scale 0x10, shift 2, bias 0x05, lanes 0x7F, 0x80, 0x02 -> 0x7F (sat), 0x80 (sat), 0x0D.
- Backpressure: count 8; s2mm tready toggled 1010... -> no beat lost or duplicated; tdata stable while stalled; mm2s tready drops while the output is full and stalled.
- Start while busy: reg0 pulse 0x66D784 then 0x66D780 (count 0x66D7), second start pulse after 10 beats -> ignored; exactly 26327 output beats, single task_finish.
- Reset mid-task: deassert s_rst_n after 3 beats -> all outputs 0 immediately; after release a new start runs normally from beat 0.
